rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data width; SIZE, default 32, register count; INDEX_W, derived $clog2(SIZE), index width.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-low: state clears on a clk edge while reset is 0.
REQ-004 a_valid, a_ready  in/out  1/1  requester A (ALU writeback) handshake.
REQ-005 a_index, a_data  input  INDEX_W/WIDTH  requester A destination and value.
REQ-006 b_valid, b_ready  in/out  1/1  requester B (load writeback) handshake.
REQ-007 b_index, b_data  input  INDEX_W/WIDTH  requester B destination and value.
REQ-008 issue_en, issue_index  input  1/INDEX_W  decode marks a destination register pending.
REQ-009 rd1_index, rd2_index  input  INDEX_W  source indices to check.
REQ-010 rd1_busy, rd2_busy  output  1  source has an outstanding write.
REQ-011 wr_en, wr_index, wr_data  output  1/INDEX_W/WIDTH  registered register-file write port.

Function
REQ-012 A transfer SHALL occur on a requester in a cycle where its valid and ready are both 1.
REQ-013 ready SHALL be combinational from valid and arbitration state, and SHALL be 1 for at most one requester per cycle.
REQ-014 With one valid requester, that requester's ready SHALL be 1 in the same cycle.
REQ-015 With both valid, the grant SHALL go to the requester not granted in the most recent contended cycle; after reset the first contended grant SHALL go to A.
REQ-016 The last-winner bit SHALL update only in cycles where both requesters are valid.
REQ-017 A transfer in cycle N SHALL produce wr_en=1 with the same index and data in cycle N+1; wr_en SHALL be 0 in cycle N+1 when no transfer occurred in N.
REQ-018 A transfer with index 0 SHALL complete the handshake and SHALL leave wr_en 0 in the following cycle.
REQ-019 valid SHALL NOT depend on ready; a requester holding valid SHALL keep index and data stable until its transfer.
REQ-020 The scoreboard SHALL hold one pending bit per index 1..SIZE-1; index 0 SHALL never be pending.
REQ-021 issue_en=1 with nonzero issue_index SHALL set that bit at the next edge.
REQ-022 wr_en=1 SHALL clear pending[wr_index] at the end of that cycle.
REQ-023 When a set and a clear target the same index in one cycle, the set SHALL win.
REQ-024 rdN_busy SHALL be pending[rdN_index] combinationally, and SHALL be 0 for index 0.
REQ-025 A write produced in cycle N+1 SHALL make busy drop from cycle N+2, matching register-file read-after-write visibility.

Reset
REQ-026 While reset=0 at an edge: wr_en, wr_index, wr_data, all pending bits and the last-winner bit SHALL clear to 0, with A preferred next.
REQ-027 During reset, a_ready and b_ready SHALL be 0 and no transfer SHALL be counted.
REQ-028 A write accepted in the cycle before reset asserts SHALL be discarded.

Structure
REQ-029 The shared package rf_pkg SHALL hold WIDTH, SIZE, INDEX_W and the requester-id enum (REQ_A, REQ_B).
REQ-030 The pending-bit array with its set/clear/query logic SHALL be one sub-module, rf_scoreboard.
REQ-031 Arbitration and the output register SHALL stay in the top module.

Verification
REQ-032 After reset, issue_en with index 5, then a_valid with index 5 and data 0xDEADBEEF -> a_ready=1; next cycle wr_en=1, wr_index=5, wr_data=0xDEADBEEF; rd1_busy (rd1_index=5) is 1 until two cycles after the transfer.
REQ-033 Both valid for 4 cycles (A index 1, B index 2) -> grants A,B,A,B; wr_index 1,2,1,2 one cycle later.
REQ-034 b_valid with index 0 and data 0x1234 -> b_ready=1; next cycle wr_en=0.
REQ-035 Index 7 pending; same cycle issue_en index 7 and wr_en index 7 -> pending[7] stays 1.
REQ-036 Transfer of index 3, then reset=0 on the next edge -> wr_en=0 and all busy=0 after that edge; arbitration resumes A-first.
REQ-037 rd2_index=0 with issue_en index 0 -> rd2_busy stays 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared parameters and types for the register-file writeback arbiter.
package rf_pkg;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 32;
    localparam int INDEX_W = $clog2(SIZE);

    // Requester identity; also the encoding of the arbitration priority bit.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // The requester that is preferred after r wins a contended cycle.
    function automatic req_id_e other_req(req_id_e r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: two requester handshakes plus the registered RF write port.
//
// Handshake: a transfer happens in any cycle where valid and ready are both 1.
// valid never waits on ready, and a requester holding valid keeps index/data
// stable until its transfer. ready is combinational from valid and the
// arbitration state, and at most one ready is high per cycle.
interface rf_wb_arbiter_if #(
    parameter int WIDTH   = rf_pkg::WIDTH,
    parameter int INDEX_W = rf_pkg::INDEX_W
);
    logic               a_valid;
    logic               a_ready;
    logic [INDEX_W-1:0] a_index;
    logic [WIDTH-1:0]   a_data;

    logic               b_valid;
    logic               b_ready;
    logic [INDEX_W-1:0] b_index;
    logic [WIDTH-1:0]   b_data;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [WIDTH-1:0]   wr_data;

    // Requester / register-file side.
    modport master (
        output a_valid, a_index, a_data,
        output b_valid, b_index, b_data,
        input  a_ready, b_ready,
        input  wr_en, wr_index, wr_data
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_index, a_data,
        input  b_valid, b_index, b_data,
        output a_ready, b_ready,
        output wr_en, wr_index, wr_data
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, index 0 never pending.
// A set and a clear of the same index in one cycle leave the bit set.
module rf_scoreboard #(
    parameter int SIZE    = rf_pkg::SIZE,
    parameter int INDEX_W = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               set_en_i,
    input  logic [INDEX_W-1:0] set_index_i,
    input  logic               clr_en_i,
    input  logic [INDEX_W-1:0] clr_index_i,
    input  logic [INDEX_W-1:0] rd1_index_i,
    input  logic [INDEX_W-1:0] rd2_index_i,
    output logic               rd1_busy_o,
    output logic               rd2_busy_o
);
    logic [SIZE-1:0] pending_q;
    logic [SIZE-1:0] pending_d;

    // Next pending state: clear first, then set so a same-index set wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_index_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_index_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending-bit register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd1_busy_o = pending_q[rd1_index_i];
    assign rd2_busy_o = pending_q[rd2_index_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin between ALU (A) and load (B) writebacks,
// registered register-file write port, and a pending-write scoreboard
// answering busy queries for two source operands.
module rf_wb_arbiter #(
    parameter int WIDTH   = rf_pkg::WIDTH,
    parameter int SIZE    = rf_pkg::SIZE,
    parameter int INDEX_W = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    rf_wb_arbiter_if.slave     bus,
    input  logic               issue_en,
    input  logic [INDEX_W-1:0] issue_index,
    input  logic [INDEX_W-1:0] rd1_index,
    input  logic [INDEX_W-1:0] rd2_index,
    output logic               rd1_busy,
    output logic               rd2_busy
);
    import rf_pkg::*;

    // Requester preferred in the next contended cycle; clears to REQ_A.
    req_id_e            prio_q;

    logic               a_ready;
    logic               b_ready;
    logic               a_xfer;
    logic               b_xfer;
    logic               xfer;
    logic [INDEX_W-1:0] sel_index;
    logic [WIDTH-1:0]   sel_data;

    logic               wr_en_q;
    logic [INDEX_W-1:0] wr_index_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic               wr_en;

    // Grant: a lone requester is served at once; contention goes to prio_q.
    // Nothing is granted while reset is low.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (reset) begin
            if (bus.a_valid && bus.b_valid) begin
                if (prio_q == REQ_A) begin
                    a_ready = 1'b1;
                end else begin
                    b_ready = 1'b1;
                end
            end else if (bus.a_valid) begin
                a_ready = 1'b1;
            end else if (bus.b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign a_xfer    = bus.a_valid && a_ready;
    assign b_xfer    = bus.b_valid && b_ready;
    assign xfer      = a_xfer || b_xfer;
    assign sel_index = a_xfer ? bus.a_index : bus.b_index;
    assign sel_data  = a_xfer ? bus.a_data  : bus.b_data;

    // Priority bit and registered write port; index 0 transfers are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q     <= REQ_A;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
        end else begin
            if (bus.a_valid && bus.b_valid) begin
                prio_q <= other_req(prio_q);
            end
            wr_en_q <= xfer && (sel_index != '0);
            if (xfer) begin
                wr_index_q <= sel_index;
                wr_data_q  <= sel_data;
            end
        end
    end

    // A write accepted just before reset falls into the reset cycle; masking
    // it with reset discards it instead of letting it reach the register file.
    assign wr_en = wr_en_q && reset;

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_index = wr_index_q;
    assign bus.wr_data  = wr_data_q;

    rf_scoreboard #(
        .SIZE    (SIZE),
        .INDEX_W (INDEX_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en_i    (issue_en),
        .set_index_i (issue_index),
        .clr_en_i    (wr_en),
        .clr_index_i (wr_index_q),
        .rd1_index_i (rd1_index),
        .rd2_index_i (rd2_index),
        .rd1_busy_o  (rd1_busy),
        .rd2_busy_o  (rd2_busy)
    );

endmodule
